// File: rtl/mysystem_switch_debounce_if.sv
// mysystem_switch_debounce_if: raw switch pins in, debounced levels and change pulses out
interface mysystem_switch_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] out_port;
  logic [WIDTH-1:0] changed;
  modport master (output sw_raw, input out_port, input changed);
  modport slave (input sw_raw, output out_port, output changed);
endinterface

// File: rtl/mysystem_switch_debounce.sv
// mysystem_switch_debounce: two-flop synchroniser plus per-bit tick-counted debounce with change pulses
module mysystem_switch_debounce #(
  parameter int WIDTH = 10,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic reset,
  mysystem_switch_debounce_if.slave sw
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  logic [WIDTH-1:0] sync1_q, sync2_q, out_q, out_d, chg_q, chg_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  assign sw.out_port = out_q;
  assign sw.changed = chg_q;
  // agreement clears a bit's count; a mismatch accepts on the tick that completes the window
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == out_q[i]) cnt_d[i] = '0;
      else if (tick && cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
        out_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        chg_d[i] = 1'b1;
      end
      else if (tick) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  // reset wins over everything, discarding any partial count
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      out_q <= RESET_VALUE;
      chg_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      sync1_q <= sw.sw_raw;
      sync2_q <= sync1_q;
      out_q <= out_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end
endmodule

// File: tb/tb_mysystem_switch_debounce.sv
// tb_mysystem_switch_debounce: directed checks of reset, acceptance latency, glitch rejection and pulses
module tb_mysystem_switch_debounce;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int dbl = 0;
  logic [9:0] prev_chg = '0;
  mysystem_switch_debounce_if #(.WIDTH(10)) sw ();
  mysystem_switch_debounce #(.WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VALUE('0)) dut (
    .clk(clk), .reset(reset), .sw(sw.slave)
  );
  always #5 clk = ~clk;
  // any bit of changed high on two consecutive cycles is a pulse-width violation
  always @(posedge clk) begin
    #1;
    if ((prev_chg & sw.changed) != '0) dbl++;
    prev_chg = sw.changed;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic wait_change(input logic [9:0] old, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sw.out_port === old && n < 40);
  endtask
  initial begin
    int n;
    int pulses;
    int acc;
    logic [9:0] acc_out;
    logic [9:0] acc_chg;
    logic hit;
    sw.sw_raw = '0;
    @(negedge clk);
    reset = 1'b1;
    sw.sw_raw = 10'h3FF;
    @(posedge clk); #1;
    check("rst_out_0", 32'(sw.out_port), 32'h0);
    check("rst_chg_0", 32'(sw.changed), 32'h0);
    @(posedge clk); #1;
    check("rst_out_1", 32'(sw.out_port), 32'h0);
    check("rst_chg_1", 32'(sw.changed), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_change(10'h000, n);
    check("rst_lat", 32'(n), 32'd12);
    check("rst_out_acc", 32'(sw.out_port), 32'h3FF);
    check("rst_chg_acc", 32'(sw.changed), 32'h3FF);
    @(posedge clk); #1;
    check("rst_chg_end", 32'(sw.changed), 32'h0);
    @(negedge clk);
    sw.sw_raw = 10'h000;
    wait_change(10'h3FF, n);
    check_rng("fall_lat", n, 11, 14);
    check("fall_out", 32'(sw.out_port), 32'h000);
    check("fall_chg", 32'(sw.changed), 32'h3FF);
    @(negedge clk);
    sw.sw_raw = 10'h001;
    wait_change(10'h000, n);
    check_rng("step_lat", n, 11, 14);
    check("step_out", 32'(sw.out_port), 32'h001);
    check("step_chg", 32'(sw.changed), 32'h001);
    @(posedge clk); #1;
    check("step_chg_end", 32'(sw.changed), 32'h0);
    check("step_out_hold", 32'(sw.out_port), 32'h001);
    @(negedge clk);
    sw.sw_raw = 10'h009;
    acc_out = '0;
    acc_chg = '0;
    repeat (6) begin
      @(posedge clk); #1;
      acc_out |= sw.out_port ^ 10'h001;
      acc_chg |= sw.changed;
    end
    @(negedge clk);
    sw.sw_raw = 10'h001;
    repeat (30) begin
      @(posedge clk); #1;
      acc_out |= sw.out_port ^ 10'h001;
      acc_chg |= sw.changed;
    end
    check("glitch_out", 32'(acc_out), 32'h0);
    check("glitch_chg", 32'(acc_chg), 32'h0);
    check("glitch_cnt", 32'(dut.cnt_q), 32'h0);
    @(negedge clk);
    sw.sw_raw = 10'h203;
    wait_change(10'h001, n);
    check_rng("simul_lat", n, 11, 14);
    check("simul_out", 32'(sw.out_port), 32'h203);
    check("simul_chg", 32'(sw.changed), 32'h202);
    @(posedge clk); #1;
    check("simul_chg_end", 32'(sw.changed), 32'h0);
    @(negedge clk);
    sw.sw_raw = 10'h207;
    wait_change(10'h203, n);
    check("bounce_pre_chg", 32'(sw.changed), 32'h004);
    pulses = 0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      sw.sw_raw = (s % 2 == 0) ? 10'h203 : 10'h207;
      repeat (3) begin
        @(posedge clk); #1;
        pulses += int'(sw.changed[2]);
      end
    end
    @(negedge clk);
    sw.sw_raw = 10'h203;
    acc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      pulses += int'(sw.changed[2]);
      if (acc == 0 && sw.out_port[2] == 1'b0) acc = k;
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check_rng("bounce_lat", acc, 11, 14);
    check("bounce_out", 32'(sw.out_port), 32'h203);
    @(negedge clk);
    sw.sw_raw = 10'h223;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk); #1;
      hit = dut.cnt_q[5] == 2'd2;
    end
    check("midrst_cnt2", 32'(hit), 32'h1);
    check("midrst_out_pre", 32'(sw.out_port), 32'h203);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_rst", 32'(sw.out_port), 32'h0);
    check("midrst_chg_rst", 32'(sw.changed), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_change(10'h000, n);
    check("midrst_lat", 32'(n), 32'd12);
    check("midrst_out", 32'(sw.out_port), 32'h223);
    check("midrst_chg", 32'(sw.changed), 32'h223);
    @(posedge clk); #1;
    check("midrst_chg_end", 32'(sw.changed), 32'h0);
    check("pulse_width", 32'(dbl), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
